dsp_mac_sequencer: RTL and testbench
====================================

# dsp_mac_sequencer

Upstream feeder for the DSP48A1 wrapper. It accepts a stream of 18-bit operand pairs over a valid/ready handshake and drives the wrapper's A, B, D, C, CARRYIN and OPMODE inputs so that the DSP accumulates a dot product in its P register. It tracks the DSP pipeline latency, captures the final P of each frame, and presents it on a one-entry result port.

## Interface
Parameters:
- DSP_LAT, 4: edges from operands on A/B to the product being in P (all DSP registers enabled).
- OPM_SKEW, 2: cycles OPMODE is delayed relative to its A/B, so OPMODE reaches the P-stage mux together with its product.

Ports:
- CLK  in  1  single clock; all logic on its rising edge.
- RSTN  in  1  reset, synchronous, active-low.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts the pair on this edge.
- in_a  in  18  multiplier operand A.
- in_b  in  18  multiplier operand B.
- in_last  in  1  marks the final pair of a frame.
- A, B  out  18  to the wrapper's A and B; registered.
- D  out  18  constant 0.
- C  out  48  constant 0.
- CARRYIN  out  1  constant 0.
- OPMODE  out  8  to the wrapper's OPMODE; registered and skewed.
- dsp_rst  out  1  high while RSTN=0; drives all wrapper RST* inputs.
- P  in  48  wrapper P output.
- res_valid  out  1  result holding.
- res_ready  in  1  consumer takes the result.
- res_data  out  48  captured P of the frame.
- res_count  out  16  pairs accepted in the frame; saturates at 65535.

## Operation
- OPMODE encodings used:
  - FIRST 8'b00000001: X=M, Z=0, pre-adder bypassed.
  - ACC 8'b00001001: X=M, Z=P.
  - HOLD 8'b00001000: X=0, Z=P.
  - IDLE 8'b00000000.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - in_ready = !res_valid.
  - Acceptance drives A/B = in_a/in_b and enqueues FIRST.
  - It also sets res_count=1 and goes to RUN.
  - If in_last is set with the acceptance, go directly to DRAIN.
- RUN:
  - in_ready = 1.
  - An accepted pair drives A/B, enqueues ACC and increments res_count.
  - A cycle with in_valid=0 drives A/B=0 and enqueues HOLD, so the accumulator is preserved across bubbles.
  - Acceptance with in_last goes to DRAIN.
- DRAIN:
  - in_ready = 0. A/B=0 and HOLD are enqueued.
  - A down-counter is loaded with DSP_LAT on entry.
  - When it expires, P is copied to res_data, res_valid is set, and the state returns to IDLE.
- OPMODE queue: an OPM_SKEW-deep shift register. IDLE state enqueues IDLE.
- Result port:
  - res_valid clears on the edge where res_valid && res_ready.
  - A new frame cannot start while res_valid=1, so a result is never overwritten.
- Arithmetic: operands pass through unmodified; the sign and width of the product are defined by the wrapper. P wraps modulo 2^48 and the block adds no saturation. res_count saturates and does not wrap.

## Timing
- Reset values (RSTN=0 at an edge):
  - State IDLE.
  - A=B=0, OPMODE=0 and the queue cleared.
  - res_valid=0, res_data=0, res_count=0.
  - in_ready=0 during reset; dsp_rst=1 combinationally while RSTN=0.
- Reset mid-frame: the frame is abandoned and no result is produced. The first cycle after release is IDLE with in_ready=1.
- A pair accepted at edge k appears on A/B after edge k. Its OPMODE appears after edge k+OPM_SKEW.
- Latency: with in_last accepted at edge k, res_valid rises after edge k+DSP_LAT+1 and res_data equals the wrapper's P at that edge.
- The earliest next acceptance is the edge after res_valid falls, or the same edge as the res_ready handshake is not allowed. in_ready is combinational on res_valid only.
- Simultaneous events: res_ready, a new in_valid and the capture edge in the same cycle are not possible, by construction of in_ready.

## Test plan
- Single pair: reset, then (20,10,last) -> res_valid after 5 edges, res_data=200 (0xC8), res_count=1.
- Two-pair frame: (20,10), (5,6,last) back-to-back -> res_data=230 (0xE6), res_count=2, OPMODE sequence FIRST, ACC, HOLD…
- Bubbles: (20,10), then 3 idle cycles, then (5,6,last) -> res_data=230. OPMODE shows HOLD during the bubbles.
- Backpressure: hold res_ready=0 after a result -> in_ready=0 and res_data stable. Pulse res_ready -> res_valid falls and the next frame starts from FIRST (no carry-over from the prior P).
- Reset mid-frame: accept (20,10), drop RSTN for 1 cycle -> all outputs zero, dsp_rst high. A following frame of (5,6,last) gives 30 (0x1E).
- Count saturation: a 65540-pair frame of (1,1) -> res_count=65535, res_data=65540.

Source files
------------

// File: rtl/dsp_mac_sequencer.sv
// Operand feeder for a DSP48A1 wrapper: streams A/B pairs into the multiplier,
// steers OPMODE so P accumulates a per-frame dot product, then captures P as a result.
module dsp_mac_sequencer #(
  parameter int DSP_LAT  = 4,
  parameter int OPM_SKEW = 2
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [17:0] in_a,
  input  logic [17:0] in_b,
  input  logic        in_last,
  output logic [17:0] A,
  output logic [17:0] B,
  output logic [17:0] D,
  output logic [47:0] C,
  output logic        CARRYIN,
  output logic [7:0]  OPMODE,
  output logic        dsp_rst,
  input  logic [47:0] P,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [47:0] res_data,
  output logic [15:0] res_count,
  output logic [1:0]  o_dbg_state
);

  // Handshakes: a pair moves on an edge where in_valid && in_ready; the result
  // is consumed on an edge where res_valid && res_ready. in_ready never depends on in_valid.

  localparam int CW = $clog2(DSP_LAT + 1);

  localparam logic [7:0] OPM_IDLE  = 8'b0000_0000;
  localparam logic [7:0] OPM_FIRST = 8'b0000_0001;
  localparam logic [7:0] OPM_ACC   = 8'b0000_1001;
  localparam logic [7:0] OPM_HOLD  = 8'b0000_1000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_in_ready;
  logic        w_accept;
  logic        w_capture;
  logic [7:0]  w_opc;
  logic [17:0] r_a;
  logic [17:0] r_b;
  logic [7:0]  r_opc;
  logic [7:0]  r_opq [OPM_SKEW];
  logic [CW-1:0] r_cnt;
  logic        r_res_valid;
  logic [47:0] r_res_data;
  logic [15:0] r_res_count;

  assign w_accept  = in_valid && w_in_ready;
  assign w_capture = (r_state == S_DRAIN) && (r_cnt == '0);

  always_ff @(posedge CLK) begin
    if (!RSTN) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = in_last ? S_DRAIN : S_RUN;
      S_RUN:   if (w_accept && in_last) w_next = S_DRAIN;
      S_DRAIN: if (r_cnt == '0) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Bubbles in RUN issue HOLD so the accumulator survives gaps in the stream.
  always_comb begin
    w_in_ready = 1'b0;
    w_opc      = OPM_IDLE;
    case (r_state)
      S_IDLE: begin
        w_in_ready = RSTN && !r_res_valid;
        w_opc      = (in_valid && RSTN && !r_res_valid) ? OPM_FIRST : OPM_IDLE;
      end
      S_RUN: begin
        w_in_ready = RSTN;
        w_opc      = in_valid ? OPM_ACC : OPM_HOLD;
      end
      S_DRAIN: w_opc = OPM_HOLD;
      default: w_opc = OPM_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_a         <= '0;
      r_b         <= '0;
      r_opc       <= OPM_IDLE;
      for (int i = 0; i < OPM_SKEW; i++) r_opq[i] <= OPM_IDLE;
      r_cnt       <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_count <= '0;
    end else begin
      r_a   <= w_accept ? in_a : 18'd0;
      r_b   <= w_accept ? in_b : 18'd0;
      // r_opc lines up with A/B; the queue then delays it by OPM_SKEW edges.
      r_opc <= w_opc;
      r_opq[0] <= r_opc;
      for (int i = 1; i < OPM_SKEW; i++) r_opq[i] <= r_opq[i-1];
      if (r_state != S_DRAIN && w_next == S_DRAIN) r_cnt <= CW'(DSP_LAT);
      else if (r_state == S_DRAIN && r_cnt != '0)  r_cnt <= r_cnt - CW'(1);
      if (w_accept) begin
        if (r_state == S_IDLE)            r_res_count <= 16'd1;
        else if (r_res_count != 16'hFFFF) r_res_count <= r_res_count + 16'd1;
      end
      if (w_capture) begin
        r_res_valid <= 1'b1;
        r_res_data  <= P;
      end else if (r_res_valid && res_ready) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign in_ready    = w_in_ready;
  assign A           = r_a;
  assign B           = r_b;
  assign D           = 18'd0;
  assign C           = 48'd0;
  assign CARRYIN     = 1'b0;
  assign OPMODE      = r_opq[OPM_SKEW-1];
  assign dsp_rst     = !RSTN;
  assign res_valid   = r_res_valid;
  assign res_data    = r_res_data;
  assign res_count   = r_res_count;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed bench for dsp_mac_sequencer with a small DSP48A1 model
// (A0/B0, A1/B1, M, OPMODE and P registers all enabled) closing the loop on P.
module tb_dsp_mac_sequencer;

  localparam logic [7:0] OPM_IDLE  = 8'b0000_0000;
  localparam logic [7:0] OPM_FIRST = 8'b0000_0001;
  localparam logic [7:0] OPM_ACC   = 8'b0000_1001;
  localparam logic [7:0] OPM_HOLD  = 8'b0000_1000;

  logic        CLK;
  logic        RSTN;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] in_a;
  logic [17:0] in_b;
  logic        in_last;
  logic [17:0] A, B, D;
  logic [47:0] C;
  logic        CARRYIN;
  logic [7:0]  OPMODE;
  logic        dsp_rst;
  logic [47:0] P;
  logic        res_valid;
  logic        res_ready;
  logic [47:0] res_data;
  logic [15:0] res_count;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  dsp_mac_sequencer #(.DSP_LAT(4), .OPM_SKEW(2)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .A(A), .B(B), .D(D), .C(C), .CARRYIN(CARRYIN), .OPMODE(OPMODE), .dsp_rst(dsp_rst),
    .P(P), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_count(res_count), .o_dbg_state(dbg_state)
  );

  // Clock/reset block
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Wrapper model: M = A*B three edges after A/B, P updated on the fourth.
  logic signed [17:0] m_a0, m_b0, m_a1, m_b1;
  logic signed [35:0] m_m;
  logic [7:0]         m_opm;
  logic [47:0]        m_p;
  logic [47:0]        m_x, m_z;

  always_comb begin
    m_x = (m_opm[1:0] == 2'b01) ? {{12{m_m[35]}}, m_m} : 48'd0;
    m_z = (m_opm[3:2] == 2'b10) ? m_p : 48'd0;
  end

  always @(posedge CLK) begin
    if (dsp_rst) begin
      m_a0 <= '0; m_b0 <= '0; m_a1 <= '0; m_b1 <= '0;
      m_m <= '0; m_opm <= '0; m_p <= '0;
    end else begin
      m_a0  <= A;
      m_b0  <= B;
      m_a1  <= m_a0;
      m_b1  <= m_b0;
      m_m   <= m_a1 * m_b1;
      m_opm <= OPMODE;
      m_p   <= m_z + m_x;
    end
  end
  assign P = m_p;

  // Scoreboard check
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Driver tasks
  task automatic send(input logic [17:0] a, input logic [17:0] b, input logic last);
    int n = 0;
    in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
    while (!in_ready && n < 100) begin step(); n++; end
    chk("send_ready", 64'(in_ready), 64'(1));
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_res(input int already, input string tag,
                          input logic [47:0] exp_d, input logic [15:0] exp_c);
    int lat = already;
    while (!res_valid && lat < 50) begin step(); lat++; end
    chk({tag, "_lat"},   64'(lat),       64'(5));
    chk({tag, "_data"},  64'(res_data),  64'(exp_d));
    chk({tag, "_count"}, 64'(res_count), 64'(exp_c));
    chk({tag, "_ready"}, 64'(in_ready),  64'(0));
  endtask

  task automatic take(input string tag);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk({tag, "_taken"}, 64'(res_valid), 64'(0));
  endtask

  initial begin
    RSTN = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; res_ready = 1'b0;
    repeat (3) step();
    chk("rst_state",   64'(dbg_state), 64'(0));
    chk("rst_ab",      64'({A, B}),    64'(0));
    chk("rst_opmode",  64'(OPMODE),    64'(0));
    chk("rst_rvalid",  64'(res_valid), 64'(0));
    chk("rst_rdata",   64'(res_data),  64'(0));
    chk("rst_rcount",  64'(res_count), 64'(0));
    chk("rst_inready", 64'(in_ready),  64'(0));
    chk("rst_dsprst",  64'(dsp_rst),   64'(1));
    chk("const_dcc",   64'({D, C[17:0], CARRYIN}), 64'(0));
    RSTN = 1'b1;
    #1;
    chk("rel_inready", 64'(in_ready), 64'(1));
    chk("rel_dsprst",  64'(dsp_rst),  64'(0));

    // Single pair
    send(18'd20, 18'd10, 1'b1);
    chk("s_a",      64'(A),         64'(20));
    chk("s_b",      64'(B),         64'(10));
    chk("s_state",  64'(dbg_state), 64'(2));
    chk("s_opm_k",  64'(OPMODE),    64'(OPM_IDLE));
    step();
    chk("s_opm_k1", 64'(OPMODE),    64'(OPM_IDLE));
    chk("s_a_drn",  64'(A),         64'(0));
    step();
    chk("s_opm_k2", 64'(OPMODE),    64'(OPM_FIRST));
    wait_res(2, "single", 48'd200, 16'd1);
    take("single");

    // Two-pair back-to-back frame
    send(18'd20, 18'd10, 1'b0);
    send(18'd5, 18'd6, 1'b1);
    step();
    chk("two_opm0", 64'(OPMODE), 64'(OPM_FIRST));
    step();
    chk("two_opm1", 64'(OPMODE), 64'(OPM_ACC));
    step();
    chk("two_opm2", 64'(OPMODE), 64'(OPM_HOLD));
    wait_res(3, "two", 48'd230, 16'd2);
    take("two");

    // Bubbles inside a frame
    send(18'd20, 18'd10, 1'b0);
    step();
    chk("bub_a",     64'(A),         64'(0));
    chk("bub_state", 64'(dbg_state), 64'(1));
    step();
    chk("bub_opm_f", 64'(OPMODE),    64'(OPM_FIRST));
    step();
    chk("bub_opm_h", 64'(OPMODE),    64'(OPM_HOLD));
    send(18'd5, 18'd6, 1'b1);
    wait_res(0, "bub", 48'd230, 16'd2);

    // Backpressure: pending pair must wait while the result is held
    in_a = 18'd3; in_b = 18'd4; in_last = 1'b1; in_valid = 1'b1;
    repeat (4) step();
    chk("bp_inready", 64'(in_ready),  64'(0));
    chk("bp_state",   64'(dbg_state), 64'(0));
    chk("bp_data",    64'(res_data),  64'(230));
    chk("bp_count",   64'(res_count), 64'(2));
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("bp_taken",   64'(res_valid), 64'(0));
    chk("bp_noacc",   64'(dbg_state), 64'(0));
    chk("bp_ready2",  64'(in_ready),  64'(1));
    step();
    in_valid = 1'b0; in_last = 1'b0;
    chk("bp_acc",     64'(dbg_state), 64'(2));
    chk("bp_cnt1",    64'(res_count), 64'(1));
    wait_res(0, "bp", 48'd12, 16'd1);
    take("bp");

    // Reset mid-frame
    send(18'd20, 18'd10, 1'b0);
    RSTN = 1'b0;
    #1;
    chk("mr_dsprst",  64'(dsp_rst),  64'(1));
    chk("mr_inready", 64'(in_ready), 64'(0));
    step();
    chk("mr_state",   64'(dbg_state), 64'(0));
    chk("mr_ab",      64'({A, B}),    64'(0));
    chk("mr_opm",     64'(OPMODE),    64'(0));
    chk("mr_count",   64'(res_count), 64'(0));
    chk("mr_rvalid",  64'(res_valid), 64'(0));
    RSTN = 1'b1;
    #1;
    chk("mr_rel_rdy", 64'(in_ready),  64'(1));
    send(18'd5, 18'd6, 1'b1);
    wait_res(0, "mr", 48'd30, 16'd1);
    take("mr");

    // Count saturation: 65540 pairs of (1,1)
    in_a = 18'd1; in_b = 18'd1; in_last = 1'b0; in_valid = 1'b1;
    chk("sat_ready", 64'(in_ready), 64'(1));
    for (int i = 1; i <= 65539; i++) begin
      step();
      if (i == 65534) chk("sat_pre",  64'(res_count), 64'(65534));
      if (i == 65535) chk("sat_at",   64'(res_count), 64'(65535));
      if (i == 65537) chk("sat_hold", 64'(res_count), 64'(65535));
    end
    in_last = 1'b1;
    step();
    in_valid = 1'b0; in_last = 1'b0;
    wait_res(0, "sat", 48'd65540, 16'd65535);
    take("sat");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
